// File: rtl/register_file_ctx.sv
// Purpose: WIDTH x DEPTH register file with 3 async read ports, 1 sync write port and a one-deep shadow context.
// Latency: reads combinational (same-cycle forwarding when BYPASS=1); save/restore copies one register per cycle, DEPTH cycles total.
// Backpressure: busy is high while a copy runs; architectural writes and new commands are dropped, not queued.
//
// Ports:
//   clk, reset                         clock, asynchronous active-high reset (clears both banks and sequencer)
//   write_enable/write_addr/write_data write port into the active bank
//   read_a/b/c -> read_a/b/c_data      combinational reads of the active bank
//   ctx_save, ctx_restore              start copy active->shadow / shadow->active (save wins if both)
//   busy, done                         copy in progress; one-cycle pulse after the final copy edge
module register_file_ctx #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int BYPASS = 0,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_enable,
    input  logic [AW-1:0]    write_addr,
    input  logic [WIDTH-1:0] write_data,
    input  logic [AW-1:0]    read_a,
    input  logic [AW-1:0]    read_b,
    input  logic [AW-1:0]    read_c,
    output logic [WIDTH-1:0] read_a_data,
    output logic [WIDTH-1:0] read_b_data,
    output logic [WIDTH-1:0] read_c_data,
    input  logic             ctx_save,
    input  logic             ctx_restore,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             done_q, done_d;
    logic             wr_fire;
    logic             last_idx;

    logic [WIDTH-1:0] active_q [DEPTH];
    logic [WIDTH-1:0] shadow_q [DEPTH];

    // busy is a pure decode of the state so it can never disagree with it.
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign wr_fire  = write_enable && !busy;
    assign last_idx = (idx_q == AW'(DEPTH - 1));

    // Sequencer next-state logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctx_save) begin
                    state_d = SAVE;
                    idx_d   = '0;
                end else if (ctx_restore) begin
                    state_d = RESTORE;
                    idx_d   = '0;
                end
            end
            SAVE, RESTORE: begin
                if (last_idx) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Active bank: architectural writes only when idle, so they never collide
    // with a restore copy into the same bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) active_q[i] <= '0;
        end else if (wr_fire) begin
            active_q[write_addr] <= write_data;
        end else if (state_q == RESTORE) begin
            active_q[idx_q] <= shadow_q[idx_q];
        end
    end

    // Shadow bank. A write in the same cycle as the save command lands in the
    // active bank at the command edge, before entry 0 is copied one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) shadow_q[i] <= '0;
        end else if (state_q == SAVE) begin
            shadow_q[idx_q] <= active_q[idx_q];
        end
    end

    // Read ports; forwarding is gated by wr_fire, so it is off while busy.
    always_comb begin
        read_a_data = active_q[read_a];
        read_b_data = active_q[read_b];
        read_c_data = active_q[read_c];
        if ((BYPASS != 0) && wr_fire) begin
            if (read_a == write_addr) read_a_data = write_data;
            if (read_b == write_addr) read_b_data = write_data;
            if (read_c == write_addr) read_c_data = write_data;
        end
    end

endmodule
